// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester (instruction fetch / data) arbiter in front of a
// single-port word-addressed memory with one-cycle read latency.
// Data requests win conflicts, except that an instruction fetch that has seen
// STARVE_MAX consecutive data grants while waiting is granted next.
// Optional build macro MEM_ARB_STATS_EN adds saturating grant/conflict counters.
module mem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_gnt,
    output logic                  i_rvalid,
    output logic [DATA_WIDTH-1:0] i_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-3:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [31:0]           stat_i_gnt,
    output logic [31:0]           stat_d_gnt,
    output logic [31:0]           stat_conflict
`endif
);

    localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        RD_NONE,
        RD_I,
        RD_D
    } owner_t;

    owner_t           owner;
    owner_t           owner_next;
    logic [CNT_W-1:0] starve_cnt;
    logic             starved;
    logic             unused_addr_bits;

    // Byte offset bits are irrelevant to a word-addressed memory.
    assign unused_addr_bits = ^{i_addr[1:0], d_addr[1:0]};

    assign starved = (starve_cnt == CNT_W'(STARVE_MAX));

    // Grant decision: data wins conflicts unless the fetch side is starved; nothing is granted in reset.
    always_comb begin
        i_gnt = 1'b0;
        d_gnt = 1'b0;
        if (!rst) begin
            if (i_req && d_req) begin
                if (starved) begin
                    i_gnt = 1'b1;
                end else begin
                    d_gnt = 1'b1;
                end
            end else if (i_req) begin
                i_gnt = 1'b1;
            end else if (d_req) begin
                d_gnt = 1'b1;
            end
        end
    end

    // Memory port is driven straight from whichever requester holds the grant.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (i_gnt) begin
            mem_en    = 1'b1;
            mem_addr  = i_addr[ADDR_WIDTH-1:2];
            mem_wdata = d_wdata;
        end else if (d_gnt) begin
            mem_en    = 1'b1;
            mem_we    = d_we;
            mem_addr  = d_addr[ADDR_WIDTH-1:2];
            mem_wdata = d_wdata;
        end
    end

    // Count consecutive data grants that bypassed a waiting fetch; cleared once the fetch is served or withdrawn.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (i_gnt || !i_req) begin
            starve_cnt <= '0;
        end else if (d_gnt && !starved) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

    // Read-owner state register: remembers who issued the read whose data returns next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner <= RD_NONE;
        end else begin
            owner <= owner_next;
        end
    end

    // Next read owner follows this cycle's grant; stores produce no returning data.
    always_comb begin
        owner_next = RD_NONE;
        if (i_gnt) begin
            owner_next = RD_I;
        end else if (d_gnt && !d_we) begin
            owner_next = RD_D;
        end
    end

    // Steer returning memory data to its owner; reset suppresses a response still in flight.
    always_comb begin
        i_rvalid = 1'b0;
        d_rvalid = 1'b0;
        i_rdata  = '0;
        d_rdata  = '0;
        if (!rst) begin
            if (owner == RD_I) begin
                i_rvalid = 1'b1;
                i_rdata  = mem_rdata;
            end else if (owner == RD_D) begin
                d_rvalid = 1'b1;
                d_rdata  = mem_rdata;
            end
        end
    end

`ifdef MEM_ARB_STATS_EN
    // Saturating event counters for grants and request conflicts.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_i_gnt    <= '0;
            stat_d_gnt    <= '0;
            stat_conflict <= '0;
        end else begin
            if (i_gnt && (stat_i_gnt != '1)) begin
                stat_i_gnt <= stat_i_gnt + 32'd1;
            end
            if (d_gnt && (stat_d_gnt != '1)) begin
                stat_d_gnt <= stat_d_gnt + 32'd1;
            end
            if (i_req && d_req && (stat_conflict != '1)) begin
                stat_conflict <= stat_conflict + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter with a
// behavioural single-port memory and a read-response scoreboard.
// Build with MEM_ARB_STATS_EN defined to also check the statistics counters.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_gnt;
    logic        i_rvalid;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
`ifdef MEM_ARB_STATS_EN
    logic [31:0] stat_i_gnt;
    logic [31:0] stat_d_gnt;
    logic [31:0] stat_conflict;
    int          exp_stat_i;
    int          exp_stat_d;
    int          exp_stat_c;
`endif

    typedef struct {
        logic        iv;
        logic        dv;
        logic [31:0] data;
    } rsp_t;

    rsp_t        sb[$];
    logic [31:0] mem[0:255];
    int          checks;
    int          errors;

    mem_arbiter #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(32),
        .STARVE_MAX(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_gnt    (i_gnt),
        .i_rvalid (i_rvalid),
        .i_rdata  (i_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_gnt    (d_gnt),
        .d_rvalid (d_rvalid),
        .d_rdata  (d_rdata),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
`ifdef MEM_ARB_STATS_EN
        ,
        .stat_i_gnt   (stat_i_gnt),
        .stat_d_gnt   (stat_d_gnt),
        .stat_conflict(stat_conflict)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural memory: loaded with known contents during reset, one-cycle read latency, junk when idle.
    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 256; k++) begin
                mem[k] <= 32'h1000_0000 + k;
            end
            mem[2]    <= 32'h00C0_FFEE;
            mem_rdata <= 32'hDEAD_BEEF;
        end else if (mem_en) begin
            if (mem_we) begin
                mem[mem_addr[7:0]] <= mem_wdata;
                mem_rdata          <= 32'hDEAD_BEEF;
            end else begin
                mem_rdata <= mem[mem_addr[7:0]];
            end
        end else begin
            mem_rdata <= 32'hDEAD_BEEF;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic ir, input logic [31:0] ia,
                                 input logic dr, input logic dwe, input logic [31:0] da,
                                 input logic [31:0] dwd);
        rst     = r;
        i_req   = ir;
        i_addr  = ia;
        d_req   = dr;
        d_we    = dwe;
        d_addr  = da;
        d_wdata = dwd;
    endtask

    task automatic checkOutput(input string tag, input logic eig, input logic edg);
        logic        e_we;
        logic [29:0] e_addr;
        logic [31:0] e_wdata;
        rsp_t        e;
        rsp_t        nxt;

        e_we    = 1'b0;
        e_addr  = '0;
        e_wdata = '0;
        if (eig) begin
            e_addr  = i_addr[31:2];
            e_wdata = d_wdata;
        end else if (edg) begin
            e_we    = d_we;
            e_addr  = d_addr[31:2];
            e_wdata = d_wdata;
        end

        chk({tag, ".i_gnt"}, 64'(i_gnt), 64'(eig));
        chk({tag, ".d_gnt"}, 64'(d_gnt), 64'(edg));
        chk({tag, ".mem_en"}, 64'(mem_en), 64'(eig | edg));
        chk({tag, ".mem_we"}, 64'(mem_we), 64'(e_we));
        chk({tag, ".mem_addr"}, 64'(mem_addr), 64'(e_addr));
        chk({tag, ".mem_wdata"}, 64'(mem_wdata), 64'(e_wdata));

        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("[TB] FAIL %s.scoreboard observed=empty expected=entry", tag);
            e = '{iv: 1'b0, dv: 1'b0, data: 32'h0};
        end else begin
            e = sb.pop_front();
        end
        if (rst) begin
            e = '{iv: 1'b0, dv: 1'b0, data: 32'h0};
        end
        chk({tag, ".i_rvalid"}, 64'(i_rvalid), 64'(e.iv));
        chk({tag, ".d_rvalid"}, 64'(d_rvalid), 64'(e.dv));
        chk({tag, ".i_rdata"}, 64'(i_rdata), e.iv ? 64'(e.data) : 64'h0);
        chk({tag, ".d_rdata"}, 64'(d_rdata), e.dv ? 64'(e.data) : 64'h0);

`ifdef MEM_ARB_STATS_EN
        chk({tag, ".stat_i_gnt"}, 64'(stat_i_gnt), 64'(exp_stat_i));
        chk({tag, ".stat_d_gnt"}, 64'(stat_d_gnt), 64'(exp_stat_d));
        chk({tag, ".stat_conflict"}, 64'(stat_conflict), 64'(exp_stat_c));
        if (rst) begin
            exp_stat_i = 0;
            exp_stat_d = 0;
            exp_stat_c = 0;
        end else begin
            exp_stat_i += int'(eig);
            exp_stat_d += int'(edg);
            exp_stat_c += int'(i_req & d_req);
        end
`endif

        nxt = '{iv: 1'b0, dv: 1'b0, data: 32'h0};
        if (!rst && eig) begin
            nxt = '{iv: 1'b1, dv: 1'b0, data: mem[i_addr[9:2]]};
        end else if (!rst && edg && !d_we) begin
            nxt = '{iv: 1'b0, dv: 1'b1, data: mem[d_addr[9:2]]};
        end
        sb.push_back(nxt);
    endtask

    task automatic step(input string tag, input logic r, input logic ir, input logic [31:0] ia,
                        input logic dr, input logic dwe, input logic [31:0] da,
                        input logic [31:0] dwd, input logic eig, input logic edg);
        @(posedge clk);
        #1;
        applyStimulus(r, ir, ia, dr, dwe, da, dwd);
        @(negedge clk);
        checkOutput(tag, eig, edg);
    endtask

    initial begin
        logic grant_i;
        clk    = 1'b0;
        checks = 0;
        errors = 0;
`ifdef MEM_ARB_STATS_EN
        exp_stat_i = 0;
        exp_stat_d = 0;
        exp_stat_c = 0;
`endif
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        sb.push_back('{iv: 1'b0, dv: 1'b0, data: 32'h0});

        $display("[TB] reset with both requests pending");
        step("rst0", 1, 1, 32'h8, 1, 0, 32'h84, 32'h5, 0, 0);
        step("rst1", 1, 1, 32'h8, 1, 0, 32'h84, 32'h5, 0, 0);

        $display("[TB] single fetch and store");
        step("ifetch", 0, 1, 32'h8, 0, 0, 32'h0, 32'h0, 1, 0);
        step("ifetch_rsp", 0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0);
        step("store", 0, 0, 32'h0, 1, 1, 32'h84, 32'd50, 0, 1);
        step("store_idle", 0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0);

        $display("[TB] back-to-back fetch then load");
        step("b2b_i", 0, 1, 32'h8, 0, 0, 32'h0, 32'h0, 1, 0);
        step("b2b_d", 0, 0, 32'h0, 1, 0, 32'h84, 32'h0, 0, 1);
        step("b2b_idle", 0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0);

        $display("[TB] sustained conflict, starvation pattern");
        for (int k = 0; k < 10; k++) begin
            grant_i = (k == 4) || (k == 9);
            step($sformatf("starve%0d", k), 0, 1, 32'h10, 1, 0, 32'h20, 32'h0, grant_i, !grant_i);
        end

        $display("[TB] fetch withdrawal clears starvation count");
        for (int k = 0; k < 3; k++) begin
            step($sformatf("pre%0d", k), 0, 1, 32'h14, 1, 0, 32'h28, 32'h0, 0, 1);
        end
        step("withdraw", 0, 0, 32'h0, 1, 0, 32'h2C, 32'h0, 0, 1);
        for (int k = 0; k < 5; k++) begin
            grant_i = (k == 4);
            step($sformatf("post%0d", k), 0, 1, 32'h18, 1, 0, 32'h30, 32'h0, grant_i, !grant_i);
        end

        $display("[TB] conflict with a store");
        step("cstore", 0, 1, 32'h18, 1, 1, 32'h34, 32'hA5A5_0001, 0, 1);
        step("cstore_i", 0, 1, 32'h18, 0, 0, 32'h0, 32'h0, 1, 0);
        step("cstore_ld", 0, 0, 32'h0, 1, 0, 32'h34, 32'h0, 0, 1);
        step("cstore_idle", 0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0);

        $display("[TB] reset right after a load grant");
        step("ld_pre_rst", 0, 0, 32'h0, 1, 0, 32'h24, 32'h0, 0, 1);
        step("rst_kill", 1, 1, 32'h8, 1, 0, 32'h24, 32'h7, 0, 0);
        step("after_rst", 0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0);
        step("rst_cnt0", 0, 1, 32'h8, 1, 0, 32'h24, 32'h0, 0, 1);
        step("final_idle", 0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0);

        @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
